// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first ripple-borrow subtractor driven by two active-low board keys.
// Define SERIAL_SUB_ABS_EN to add a NEG step so LEDG shows |A-B| with LEDG8 as the sign.
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             KEY0,
   input  logic             KEY1,
   input  logic [WIDTH-1:0] SW1,
   input  logic [WIDTH-1:0] SW2,
   output logic [WIDTH-1:0] LEDR1,
   output logic [WIDTH-1:0] LEDR2,
   output logic [WIDTH-1:0] LEDG,
   output logic             LEDG8,
   output logic             busy,
   output logic             done
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_NEG,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_diff;
   logic             r_brw;
   logic [BW-1:0]    r_bit_cnt;
   logic [DW-1:0]    r_div_cnt;
   logic [WIDTH-1:0] r_ledr1;
   logic [WIDTH-1:0] r_ledr2;
   logic [WIDTH-1:0] r_ledg;
   logic             r_ledg8;

   logic [1:0] w_key_pin;
   logic [1:0] w_press;
   logic       w_clr;
   logic       w_start;
   logic       w_step;
   logic       w_last;
   logic       w_d;
   logic       w_brw_next;

   assign w_key_pin = {KEY1, KEY0};

   // Two-flop sync per key; flops idle at 1 so a key held through reset never fires.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_key
         logic r_k_r;
         logic r_k_rr;
         always_ff @(posedge clk) begin
            if (reset) begin
               r_k_r  <= 1'b1;
               r_k_rr <= 1'b1;
            end else begin
               r_k_r  <= w_key_pin[gi];
               r_k_rr <= r_k_r;
            end
         end
         assign w_press[gi] = r_k_rr & ~r_k_r;
      end
   endgenerate

   assign w_clr   = w_press[0];
   assign w_start = w_press[1];

   assign w_step     = (r_div_cnt == DIV_LAST);
   assign w_last     = w_step && (r_bit_cnt == BIT_LAST);
   assign w_d        = r_a[0] ^ r_b[0] ^ r_brw;
   assign w_brw_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Clear takes priority over everything, including a start in the same cycle.
   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start && !w_clr) begin
               w_state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy = 1'b1;
            if (w_clr) begin
               w_state_next = S_IDLE;
            end else if (w_last) begin
`ifdef SERIAL_SUB_ABS_EN
               w_state_next = w_brw_next ? S_NEG : S_DONE;
`else
               w_state_next = S_DONE;
`endif
            end
         end
`ifdef SERIAL_SUB_ABS_EN
         S_NEG: begin
            busy         = 1'b1;
            w_state_next = w_clr ? S_IDLE : S_DONE;
         end
`endif
         S_DONE: begin
            busy         = 1'b1;
            done         = !w_clr;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a       <= '0;
         r_b       <= '0;
         r_diff    <= '0;
         r_brw     <= 1'b0;
         r_bit_cnt <= '0;
         r_div_cnt <= '0;
         r_ledr1   <= '0;
         r_ledr2   <= '0;
         r_ledg    <= '0;
         r_ledg8   <= 1'b0;
      end else begin
         r_ledr1 <= SW1;
         r_ledr2 <= SW2;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_a       <= SW1;
                  r_b       <= SW2;
                  r_brw     <= 1'b0;
                  r_bit_cnt <= '0;
                  r_div_cnt <= '0;
               end
            end
            S_SHIFT: begin
               if (w_step) begin
                  r_div_cnt <= '0;
                  r_brw     <= w_brw_next;
                  r_diff    <= {w_d, r_diff[WIDTH-1:1]};
                  r_a       <= r_a >> 1;
                  r_b       <= r_b >> 1;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
`ifdef SERIAL_SUB_ABS_EN
            S_NEG: begin
               r_diff <= ~r_diff + 1'b1;
            end
`endif
            S_DONE: begin
               r_ledg  <= r_diff;
               r_ledg8 <= r_brw;
            end
            default: begin
            end
         endcase
         if (w_clr) begin
            r_ledg  <= '0;
            r_ledg8 <= 1'b0;
         end
      end
   end

   assign LEDR1 = r_ledr1;
   assign LEDR2 = r_ledr2;
   assign LEDG  = r_ledg;
   assign LEDG8 = r_ledg8;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial 8-bit subtractor, the inverse operation of the board's push-to-add unit.
- Operand A is read from SW1 and operand B from SW2. A falling edge on KEY1 (press) starts an LSB-first ripple-borrow subtraction. The difference goes to LEDG and the borrow to LEDG8.
- KEY0 press clears the result. Debounce-free two-flop edge detection per key is built in; it sits directly on board pins.

Parameters:
- WIDTH, 8: operand/result width in bits.
- DIV, 1: clock cycles per bit step (≥1); slows the shift so progress can be watched on hardware.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- KEY0  input  1  clear key, active-low (pressed = 0)
- KEY1  input  1  start key, active-low
- SW1  input  WIDTH  minuend A
- SW2  input  WIDTH  subtrahend B
- LEDR1  output  WIDTH  registered copy of SW1
- LEDR2  output  WIDTH  registered copy of SW2
- LEDG  output  WIDTH  difference A-B (mod 2^WIDTH)
- LEDG8  output  1  borrow (1 when A<B)
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when LEDG/LEDG8 update

Behaviour:
- Reset is synchronous. It takes effect at the clock edge, on any state.
  - LEDG=0, LEDG8=0, LEDR1=0, LEDR2=0, busy=0, done=0, FSM=IDLE.
  - Key sync flops are set to 1 (released).
- LEDR1/LEDR2 are SW1/SW2 delayed by one cycle, every cycle.
- Key edge detection:
  - Each key has two sync flops, k_r <= KEY, k_rr <= k_r.
  - press = k_rr & ~k_r, which is a 1-cycle pulse on the high-to-low transition.
  - The pulse is high 2 cycles after the pin falls.
  - A held key yields exactly one pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start pulse: latch a<=SW1, b<=SW2 (the live switch value in the pulse cycle), brw<=0, bit_cnt<=0, div_cnt<=0, then go to SHIFT.
- SHIFT:
  - div_cnt counts 0..DIV-1. A bit step happens when div_cnt==DIV-1.
  - Bit step: d = a[0]^b[0]^brw; brw <= (~a[0]&b[0]) | (~(a[0]^b[0])&brw); diff <= {d, diff[WIDTH-1:1]}; a, b shift right; bit_cnt++.
  - After step WIDTH, go to DONE.
- DONE, one cycle: LEDG<=diff, LEDG8<=brw, done=1, then go to IDLE.
- busy=1 in SHIFT and DONE. LEDG/LEDG8 hold their value between operations.
- Latency (start pulse in cycle T):
  - done high in cycle T+WIDTH*DIV+1.
  - New LEDG visible from T+WIDTH*DIV+2.
  - With DIV=1, WIDTH=8: done at T+9.
- Start pulse while busy: ignored. The operation continues with the latched operands.
- Switch changes while busy: no effect on the result.
- Clear pulse:
  - LEDG<=0, LEDG8<=0.
  - Any operation in progress is aborted: FSM to IDLE, busy=0, no done.
- Clear and start pulses in the same cycle: clear wins, start is discarded.
- Arithmetic: LEDG = (A-B) mod 2^WIDTH, LEDG8 = (A<B), unsigned.
- Zero operands and A==B are not special: LEDG=0, LEDG8=0.

Optional Feature:
- SERIAL_SUB_ABS_EN defined:
  - When the final borrow=1, DONE is preceded by one extra NEG state that sets diff <= ~diff+1.
  - LEDG then shows |A-B| and LEDG8 acts as the sign (1 = negative).
  - Latency becomes WIDTH*DIV+2 for borrow cases only; non-borrow results keep the base latency.
  - Clear during NEG aborts like SHIFT.
- Undefined: no NEG state; LEDG is the raw mod-2^WIDTH difference.

Test Plan:
- Basic subtraction: SW1=0x05, SW2=0x03, press KEY1 → done 9 cycles after the start pulse; LEDG=0x02, LEDG8=0, busy high for exactly 9 cycles.
- Borrow case: SW1=0x03, SW2=0x05, press KEY1 → LEDG=0xFE, LEDG8=1. With SERIAL_SUB_ABS_EN: LEDG=0x02, LEDG8=1, done at 10 cycles.
- Edge values:
  - 0xFF-0x01 → 0xFE/0.
  - 0x00-0x00 → 0x00/0.
  - 0x00-0xFF → 0x01/1 (ABS: 0xFF/1).
- Busy and held-key behaviour:
  - Start with 0x10-0x01; change SW1 to 0x80 and press KEY1 again mid-shift → single done, LEDG=0x0F.
  - Holding KEY1 low for 50 cycles starts only once.
- Clear behaviour:
  - Press KEY0 in shift cycle 4 → busy drops next cycle, no done, LEDG=0x00, LEDG8=0.
  - KEY0 and KEY1 falling in the same cycle → no operation, LEDG=0.
- DIV=4 timing and reset: 0x09-0x04 → done at T+33, LEDG=0x05. Assert reset mid-shift → all outputs 0 next cycle, FSM IDLE.
